// File: rtl/median_window_ctrl.sv
// Sequencer for a 3x3 median filter: shift enable, frame/centre position, window tags and tag delay pipe.
// Define BORDER_EN for full-size output with end-of-frame flush and border tags; default is interior-only.
module median_window_ctrl #(
    parameter int unsigned IMG_W    = 64,
    parameter int unsigned IMG_H    = 64,
    parameter int unsigned PIPE_LAT = 4,
    parameter int unsigned CW       = $clog2(IMG_W),
    parameter int unsigned RW       = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    output logic          in_ready,
    output logic          shift_ce,
    output logic          flush_active,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          win_valid,
    output logic          win_border,
    output logic          out_valid,
    output logic          out_border,
    output logic          out_eof,
    output logic          busy,
    output logic          err_sof
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    state_t              state;
    logic [CW-1:0]       ncol;
    logic [RW-1:0]       nrow;
    logic                win_eof;
    logic                accept;
    logic                last_pix;
    logic [PIPE_LAT-1:0] pv;
    logic [PIPE_LAT-1:0] pb;
    logic [PIPE_LAT-1:0] pe;

    assign accept   = in_valid & in_ready & ((state == RUN) | in_sof);
    assign shift_ce = accept | (state == FLUSH);
    assign last_pix = (ncol == COL_LAST) && (nrow == ROW_LAST);

`ifdef BORDER_EN
    localparam int unsigned FW = $clog2(IMG_W + 1);

    logic [FW-1:0] fcnt;
    logic [CW-1:0] ccol;
    logic [RW-1:0] crow;
    logic          cen_on;
    logic          cen_fire;
    logic          cen_last;

    // Centre tracking begins when pixel (1,1) is shifted in and runs through the flush.
    assign cen_fire = ((state == FLUSH) | (accept & (state == RUN) & ~in_sof))
                    & (cen_on | ((ncol == CW'(1)) & (nrow == RW'(1))));
    assign cen_last = (crow == ROW_LAST) && (ccol == COL_LAST);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            flush_active <= 1'b0;
            col          <= '0;
            row          <= '0;
            ncol         <= '0;
            nrow         <= '0;
            win_valid    <= 1'b0;
            win_border   <= 1'b0;
            win_eof      <= 1'b0;
            busy         <= 1'b0;
            err_sof      <= 1'b0;
`ifdef BORDER_EN
            fcnt         <= '0;
            ccol         <= '0;
            crow         <= '0;
            cen_on       <= 1'b0;
`endif
        end else begin
            err_sof    <= in_valid & in_sof & (state != IDLE);
            win_valid  <= 1'b0;
            win_border <= 1'b0;
            win_eof    <= 1'b0;
            if (out_eof && (state == IDLE)) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE, RUN: begin
                    if (accept) begin
                        if (in_sof) begin
                            // Any sof restarts the frame with this pixel as (0,0)
                            state <= RUN;
                            col   <= '0;
                            row   <= '0;
                            ncol  <= CW'(1);
                            nrow  <= '0;
                            busy  <= 1'b1;
`ifdef BORDER_EN
                            ccol   <= '0;
                            crow   <= '0;
                            cen_on <= 1'b0;
`endif
                        end else begin
                            col <= ncol;
                            row <= nrow;
                            if (last_pix) begin
                                ncol <= '0;
                                nrow <= '0;
                            end else if (ncol == COL_LAST) begin
                                ncol <= '0;
                                nrow <= nrow + RW'(1);
                            end else begin
                                ncol <= ncol + CW'(1);
                            end
`ifdef BORDER_EN
                            if (last_pix) begin
                                state        <= FLUSH;
                                in_ready     <= 1'b0;
                                flush_active <= 1'b1;
                                fcnt         <= '0;
                            end
`else
                            win_valid <= (nrow >= RW'(2)) && (ncol >= CW'(2));
                            win_eof   <= last_pix;
                            if (last_pix) begin
                                state <= IDLE;
                            end
`endif
                        end
                    end
                end
`ifdef BORDER_EN
                FLUSH: begin
                    fcnt <= fcnt + FW'(1);
                    if (fcnt == FW'(IMG_W)) begin
                        state        <= IDLE;
                        in_ready     <= 1'b1;
                        flush_active <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
`ifdef BORDER_EN
            if (cen_fire) begin
                win_valid  <= 1'b1;
                win_border <= (crow == '0) || (crow == ROW_LAST) || (ccol == '0) || (ccol == COL_LAST);
                win_eof    <= cen_last;
                cen_on     <= ~cen_last;
                if (ccol == COL_LAST) begin
                    ccol <= '0;
                    crow <= (crow == ROW_LAST) ? '0 : crow + RW'(1);
                end else begin
                    ccol <= ccol + CW'(1);
                end
            end
`endif
        end
    end

    // Tag delay pipe matching the sorter latency; advances every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            pb <= '0;
            pe <= '0;
        end else begin
            pv[0] <= win_valid;
            pb[0] <= win_border;
            pe[0] <= win_eof;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                pv[i] <= pv[i-1];
                pb[i] <= pb[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

    assign out_valid  = pv[PIPE_LAT-1];
    assign out_border = pb[PIPE_LAT-1];
    assign out_eof    = pe[PIPE_LAT-1];

endmodule

// File: tb/tb_median_window_ctrl.sv
// Directed bench for median_window_ctrl at 8x6, latency 4; follows BORDER_EN if defined.
module tb_median_window_ctrl;
    localparam int unsigned IMG_W    = 8;
    localparam int unsigned IMG_H    = 6;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned CW       = 3;
    localparam int unsigned RW       = 3;
`ifdef BORDER_EN
    localparam bit BORD = 1'b1;
`else
    localparam bit BORD = 1'b0;
`endif
    localparam int EXP_OUT    = BORD ? 48 : 24;
    localparam int EXP_BORD   = BORD ? 24 : 0;
    localparam int EXP_FLUSH  = BORD ? 9 : 0;
    localparam int EXP_SHIFT  = BORD ? 57 : 48;
    localparam int CENTRE_PIX = BORD ? 9 : 18;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic          shift_ce;
    logic          flush_active;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          win_valid;
    logic          win_border;
    logic          out_valid;
    logic          out_border;
    logic          out_eof;
    logic          busy;
    logic          err_sof;

    median_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(in_ready), .shift_ce(shift_ce), .flush_active(flush_active),
        .col(col), .row(row), .win_valid(win_valid), .win_border(win_border),
        .out_valid(out_valid), .out_border(out_border), .out_eof(out_eof),
        .busy(busy), .err_sof(err_sof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic v;
        logic s;
        logic sh;
        logic rdy;
        logic bsy;
        logic err;
        logic win;
        int   r;
        int   c;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc, n_shift, n_out, n_bord, n_eof, eof_idx, eof_cyc;
    int   first_win, first_out, busy_fall, n_flush, n_err;
    logic prev_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_stats();
        cyc = 0; n_shift = 0; n_out = 0; n_bord = 0; n_eof = 0; eof_idx = -1; eof_cyc = -1;
        first_win = -1; first_out = -1; busy_fall = -1; n_flush = 0; n_err = 0;
        prev_busy = busy;
    endtask

    task automatic sample();
        cyc++;
        if (shift_ce) n_shift++;
        if (out_valid) begin
            n_out++;
            if (first_out < 0) first_out = cyc;
        end
        if (out_border) n_bord++;
        if (out_eof) begin
            n_eof++;
            eof_idx = n_out;
            eof_cyc = cyc;
        end
        if (win_valid && first_win < 0) first_win = cyc;
        if (flush_active && !in_ready) n_flush++;
        if (err_sof) n_err++;
        if (prev_busy && !busy) busy_fall = cyc;
        prev_busy = busy;
    endtask

    task automatic step(input logic v, input logic s);
        in_valid = v;
        in_sof   = s;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One frame starting with sof, optional 50% gaps, then drain with non-sof pixels offered.
    task automatic run_frame(input bit gap, input int exp_err, input string tag);
        int          acc;
        bit          done;
        logic [5:0]  pos0;
        acc  = -100;
        done = 1'b0;
        clear_stats();
        step(1'b1, 1'b1);
        pos0 = {row, col};
        for (int p = 1; p < int'(IMG_W * IMG_H); p++) begin
            if (gap) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            if (p == CENTRE_PIX) acc = cyc;
        end
        for (int k = 0; k < 200 && !done; k++) begin
            step(1'b1, 1'b0);
            done = (n_eof > 0) && (busy_fall >= 0);
        end
        check({tag, "_drain_done"}, 32'(done), 32'd1);
        check({tag, "_sof_pos"}, 32'(pos0), 32'd0);
        check({tag, "_out_cnt"}, n_out, EXP_OUT);
        check({tag, "_border_cnt"}, n_bord, EXP_BORD);
        check({tag, "_eof_cnt"}, n_eof, 1);
        check({tag, "_eof_idx"}, eof_idx, EXP_OUT);
        check({tag, "_first_win"}, first_win, acc + 1);
        check({tag, "_first_out"}, first_out, first_win + int'(PIPE_LAT));
        check({tag, "_busy_fall"}, busy_fall, eof_cyc + 1);
        check({tag, "_flush_cyc"}, n_flush, EXP_FLUSH);
        check({tag, "_shift_cnt"}, n_shift, EXP_SHIFT);
        check({tag, "_err_cnt"}, n_err, exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
        for (int i = 5; i <= 10; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, i - 3};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, 0};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, BORD, 1, 1};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {in_ready, busy, flush_active, win_valid, win_border, out_valid, out_border,
               out_eof, err_sof, row, col}, 32'h4000);
        check("reset_shift_ce", 32'(shift_ce), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cycle-by-cycle vectors: idle drop, sof start, gap, line wrap, mid-frame sof
        for (int i = 0; i < 16; i++) begin
            in_valid = tbl[i].v;
            in_sof   = tbl[i].s;
            @(negedge clk);
            check($sformatf("vec%0d_shift_ce", i), 32'(shift_ce), 32'(tbl[i].sh));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_regs", i),
                  {in_ready, busy, err_sof, win_valid, row, col},
                  {tbl[i].rdy, tbl[i].bsy, tbl[i].err, tbl[i].win, 3'(tbl[i].r), 3'(tbl[i].c)});
        end

        do_reset();
        run_frame(1'b0, 0, "frame");
        run_frame(1'b1, 0, "gapped");

        // Abort at pixel 20, let in-flight tags drain, then a full frame
        do_reset();
        step(1'b1, 1'b1);
        for (int p = 1; p < 20; p++) step(1'b1, 1'b0);
        check("pre_sof_pos", {row, col}, {3'd2, 3'd3});
        repeat (6) step(1'b0, 1'b0);
        run_frame(1'b0, 1, "resync");

        // Async reset during row 3
        do_reset();
        step(1'b1, 1'b1);
        for (int p = 1; p < 28; p++) step(1'b1, 1'b0);
        check("pre_rst_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("rst_mid_outputs",
              {in_ready, busy, flush_active, win_valid, win_border, out_valid, out_border,
               out_eof, err_sof, row, col}, 32'h4000);
        check("rst_mid_shift_ce", 32'(shift_ce), 32'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(1'b0, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
